// File: rtl/scu_job_sequencer.sv
// rtl/scu_job_sequencer.sv - job-level sequencer for the sparse computing unit
// Clears the SCU, streams one weight-buffer read per group, then hands off the result.
module scu_job_sequencer #(
  parameter int MAX_GROUPS = 64,
  parameter int CNT_bits   = 7,
  parameter int WA_bits    = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_mode,
  input  logic [CNT_bits-1:0] cmd_ngroups,
  input  logic [WA_bits-1:0]  cmd_wbase,
  input  logic                abort,
  input  logic                tile_valid,
  output logic                wbuf_rd_en,
  output logic [WA_bits-1:0]  wbuf_rd_addr,
  output logic                scu_mode,
  output logic                scu_clear,
  output logic                scu_en,
  output logic                res_valid,
  input  logic                res_ready,
  output logic                busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_RESULT
  } state_t;

  localparam logic [CNT_bits-1:0] MAX_CNT = CNT_bits'(MAX_GROUPS);

  state_t              state, state_d;
  logic [CNT_bits-1:0] remaining, remaining_d, req_groups;
  logic [WA_bits-1:0]  addr, addr_d, rd_addr_d;
  logic                mode_d, clear_d, en_d, rd_en_d, res_valid_d, issue;

  assign req_groups = (cmd_ngroups > MAX_CNT) ? MAX_CNT : cmd_ngroups;
  assign cmd_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);

  always_comb begin
    state_d     = state;
    remaining_d = remaining;
    addr_d      = addr;
    rd_addr_d   = wbuf_rd_addr;
    mode_d      = scu_mode;
    clear_d     = 1'b0;
    rd_en_d     = 1'b0;
    en_d        = wbuf_rd_en;
    res_valid_d = res_valid;
    issue       = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          mode_d      = cmd_mode;
          remaining_d = req_groups;
          addr_d      = cmd_wbase;
          clear_d     = 1'b1;
          state_d     = S_CLEAR;
        end
      end
      S_CLEAR: begin
        // The first read is already decided here so its data meets the SCU one cycle later.
        if (remaining == '0) begin
          state_d     = S_RESULT;
          res_valid_d = 1'b1;
        end else begin
          state_d = S_RUN;
          issue   = tile_valid;
        end
      end
      S_RUN: begin
        if (remaining == '0) state_d = S_DRAIN;
        else                 issue   = tile_valid;
      end
      S_DRAIN: begin
        state_d     = S_RESULT;
        res_valid_d = 1'b1;
      end
      S_RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      rd_en_d     = 1'b1;
      rd_addr_d   = addr;
      addr_d      = addr + WA_bits'(1);
      remaining_d = remaining - CNT_bits'(1);
    end

    // Abort kills everything in flight, including a read already on its way to the SCU.
    if (abort && state != S_IDLE) begin
      state_d     = S_IDLE;
      clear_d     = 1'b0;
      rd_en_d     = 1'b0;
      en_d        = 1'b0;
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      remaining    <= '0;
      addr         <= '0;
      wbuf_rd_addr <= '0;
      wbuf_rd_en   <= 1'b0;
      scu_mode     <= 1'b0;
      scu_clear    <= 1'b0;
      scu_en       <= 1'b0;
      res_valid    <= 1'b0;
    end else begin
      state        <= state_d;
      remaining    <= remaining_d;
      addr         <= addr_d;
      wbuf_rd_addr <= rd_addr_d;
      wbuf_rd_en   <= rd_en_d;
      scu_mode     <= mode_d;
      scu_clear    <= clear_d;
      scu_en       <= en_d;
      res_valid    <= res_valid_d;
    end
  end

endmodule

// File: tb/tb_scu_job_sequencer.sv
// tb/tb_scu_job_sequencer.sv - self-checking bench for scu_job_sequencer
// An event-schedule model predicts every output cycle by cycle; literal checks pin per-job totals.
module tb_scu_job_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0, cmd_mode = 1'b0, abort = 1'b0, tile_valid = 1'b0, res_ready = 1'b0;
  logic [6:0] cmd_ngroups = '0;
  logic [9:0] cmd_wbase = '0;
  logic       cmd_ready, wbuf_rd_en, scu_mode, scu_clear, scu_en, res_valid, busy;
  logic [9:0] wbuf_rd_addr;

  scu_job_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_ngroups(cmd_ngroups), .cmd_wbase(cmd_wbase),
    .abort(abort), .tile_valid(tile_valid), .wbuf_rd_en(wbuf_rd_en),
    .wbuf_rd_addr(wbuf_rd_addr), .scu_mode(scu_mode), .scu_clear(scu_clear),
    .scu_en(scu_en), .res_valid(res_valid), .res_ready(res_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int t = 0;
  always @(posedge clk) t <= t + 1;

  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, t);
    end
  endtask

  // Model: a job is a set of future events keyed by cycle number.
  bit         busy_m = 1'b0;
  logic       mode_m = 1'b0;
  int         acc = 0, left = 0, res_from = 0, mi;
  logic [9:0] naddr = '0;
  bit         s_clr[16], s_rd[16], s_en[16];
  logic [9:0] s_addr[16];
  bit         exp_res;

  int         en_cnt = 0, clr_cnt = 0, rd_cnt = 0, res_rel = -1, first_rd_rel = -1;
  logic [9:0] addr_log[4];

  always @(negedge clk) begin
    mi = t % 16;
    if (!rst_n) begin
      check("rst_scu_clear", scu_clear, 0);
      check("rst_scu_en", scu_en, 0);
      check("rst_rd_en", wbuf_rd_en, 0);
      check("rst_rd_addr", wbuf_rd_addr, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_scu_mode", scu_mode, 0);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_busy", busy, 0);
      busy_m = 1'b0;
      left   = 0;
      for (int k = 0; k < 16; k++) begin
        s_clr[k] = 1'b0; s_rd[k] = 1'b0; s_en[k] = 1'b0;
      end
    end else begin
      exp_res = busy_m && (t >= res_from);
      check("scu_clear", scu_clear, s_clr[mi]);
      check("scu_en", scu_en, s_en[mi]);
      check("wbuf_rd_en", wbuf_rd_en, s_rd[mi]);
      check("res_valid", res_valid, exp_res);
      check("busy", busy, busy_m);
      check("cmd_ready", cmd_ready, !busy_m);
      if (s_rd[mi]) check("wbuf_rd_addr", wbuf_rd_addr, s_addr[mi]);
      if (busy_m)   check("scu_mode", scu_mode, mode_m);

      if (scu_en)    en_cnt++;
      if (scu_clear) clr_cnt++;
      if (wbuf_rd_en) begin
        if (rd_cnt < 4) addr_log[rd_cnt] = wbuf_rd_addr;
        if (first_rd_rel < 0) first_rd_rel = t - acc;
        rd_cnt++;
      end
      if (res_valid && res_rel < 0) res_rel = t - acc;
      s_clr[mi] = 1'b0; s_rd[mi] = 1'b0; s_en[mi] = 1'b0;

      if (!busy_m) begin
        if (cmd_valid) begin
          acc      = t;
          mode_m   = cmd_mode;
          left     = (cmd_ngroups > 7'd64) ? 64 : int'(cmd_ngroups);
          naddr    = cmd_wbase;
          res_from = (left == 0) ? t + 2 : 1 << 30;
          busy_m   = 1'b1;
          s_clr[(t + 1) % 16] = 1'b1;
          en_cnt = 0; clr_cnt = 0; rd_cnt = 0; res_rel = -1; first_rd_rel = -1;
        end
      end else if (abort) begin
        busy_m = 1'b0;
        for (int k = 1; k <= 2; k++) begin
          s_clr[(t + k) % 16] = 1'b0; s_rd[(t + k) % 16] = 1'b0; s_en[(t + k) % 16] = 1'b0;
        end
      end else begin
        if (left > 0 && tile_valid) begin
          s_rd[(t + 1) % 16]   = 1'b1;
          s_addr[(t + 1) % 16] = naddr;
          s_en[(t + 2) % 16]   = 1'b1;
          naddr = naddr + 10'd1;
          left--;
          if (left == 0) res_from = t + 3;
        end
        if (exp_res && res_ready) busy_m = 1'b0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_job(input logic m, input int n, input logic [9:0] b,
                        input int stall, input int rdelay);
    cmd_valid = 1'b1; cmd_mode = m; cmd_ngroups = 7'(n); cmd_wbase = b; tile_valid = 1'b1;
    cyc();
    cmd_valid = 1'b0;
    cyc();
    if (stall > 0) begin
      tile_valid = 1'b0;
      repeat (stall) cyc();
      tile_valid = 1'b1;
    end
    for (int k = 0; k < 300 && res_valid !== 1'b1; k++) cyc();
    check("res_valid_seen", res_valid, 1);
    if (rdelay > 0) begin
      cmd_valid = 1'b1; cmd_ngroups = 7'd5;
      repeat (rdelay) cyc();
      cmd_valid = 1'b0;
    end
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
    cyc();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
    check("init_cmd_ready", cmd_ready, 1);
    check("init_busy", busy, 0);
    check("init_rd_addr", wbuf_rd_addr, 0);

    do_job(1'b1, 3, 10'h010, 0, 0);
    check("t1_addr0", addr_log[0], 10'h010);
    check("t1_addr1", addr_log[1], 10'h011);
    check("t1_addr2", addr_log[2], 10'h012);
    check("t1_first_rd", first_rd_rel, 2);
    check("t1_en_cnt", en_cnt, 3);
    check("t1_clr_cnt", clr_cnt, 1);
    check("t1_res_cycle", res_rel, 6);

    do_job(1'b0, 2, 10'h3FF, 0, 0);
    check("t2_addr0", addr_log[0], 10'h3FF);
    check("t2_addr1", addr_log[1], 10'h000);
    check("t2_en_cnt", en_cnt, 2);
    check("t2_res_cycle", res_rel, 5);

    do_job(1'b1, 4, 10'h020, 5, 0);
    check("t3_en_cnt", en_cnt, 4);
    check("t3_addr1", addr_log[1], 10'h021);
    check("t3_res_cycle", res_rel, 12);

    do_job(1'b0, 0, 10'h050, 0, 0);
    check("t4_zero_clr", clr_cnt, 1);
    check("t4_zero_en", en_cnt, 0);
    check("t4_zero_rd", rd_cnt, 0);
    check("t4_zero_res", res_rel, 2);

    do_job(1'b1, 100, 10'h200, 0, 0);
    check("t4_clamp_en", en_cnt, 64);
    check("t4_clamp_rd", rd_cnt, 64);
    check("t4_clamp_res", res_rel, 67);

    do_job(1'b0, 1, 10'h0AA, 0, 10);
    check("t5_en_cnt", en_cnt, 1);
    check("t5_res_cycle", res_rel, 4);

    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check("idle_abort_busy", busy, 0);

    cmd_valid = 1'b1; cmd_mode = 1'b1; cmd_ngroups = 7'd6; cmd_wbase = 10'h100; tile_valid = 1'b1;
    cyc();
    cmd_valid = 1'b0;
    cyc();
    cyc();
    tile_valid = 1'b0;
    cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check("t6_abort_busy", busy, 0);
    repeat (4) cyc();
    check("t6_abort_en_cnt", en_cnt, 2);
    check("t6_abort_rd_cnt", rd_cnt, 2);
    check("t6_abort_no_res", res_rel, -1);

    do_job(1'b0, 1, 10'h300, 0, 0);
    check("t6_after_abort_res", res_rel, 4);

    cmd_valid = 1'b1; cmd_mode = 1'b1; cmd_ngroups = 7'd5; cmd_wbase = 10'h040; tile_valid = 1'b1;
    cyc();
    cmd_valid = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    check("t6_reset_busy", busy, 0);
    repeat (3) cyc();
    check("t6_reset_no_res", res_rel, -1);

    do_job(1'b1, 2, 10'h005, 0, 0);
    check("t6_after_reset_en", en_cnt, 2);
    check("t6_after_reset_res", res_rel, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
